fetch_unit: RTL and testbench

Instruction fetch sequencer that owns the program counter driving the combinational instruction memory. It steps the byte address by 2 each cycle and captures each 16-bit instruction with its PC into a 2-entry prefetch buffer. It presents the results to decode over a valid/ready handshake. Control-flow redirects flush the buffer, and the unit halts cleanly at the end of the program image.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/fetch_unit.sv | 100 ++++++++++
 tb/tb_fetch_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath widths, program image bounds
// and the fetch sequencer state encoding.
package cpu_pkg;

   localparam int INSTR_W = 16;
   localparam int ADDR_W  = 16;

   localparam logic [ADDR_W-1:0] RESET_PC_DEF = 16'h0000;
   localparam logic [ADDR_W-1:0] PROG_END_DEF = 16'h0032;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } fetch_state_e;

   // Instructions are halfword aligned; the low address bit is dropped.
   function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:1], 1'b0};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead synchronous FIFO holding {pc, instruction} prefetch entries.
// Flush empties the queue and takes priority over a same-cycle push.
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = 2 * INSTR_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             one_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign one_o   = (count_q == CNT_W'(1));
   assign rdata_o = mem_q[rd_ptr_q];

   // A full queue still accepts a push when the head leaves in the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, prefetches into a small buffer
// and hands entries to decode over valid/ready, with redirect flush and halt.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
   parameter logic [ADDR_W-1:0] PROG_END = PROG_END_DEF,
   parameter int                DEPTH    = 2
) (
   input  logic               clk,
   input  logic               rst,
   output logic [ADDR_W-1:0]  pc,
   input  logic [INSTR_W-1:0] instruction,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr_out,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               halted
);

   localparam int ENTRY_W = ADDR_W + INSTR_W;

   fetch_state_e        state_q;
   logic [ADDR_W-1:0]   pc_q, pc_inc_d, redir_tgt_d;
   logic                halted_q;
   logic                fifo_full, fifo_empty, fifo_one;
   logic                push_d, pop_d, pc_in_range_d;
   logic [ENTRY_W-1:0]  head_entry;

   assign pc_inc_d      = pc_q + ADDR_W'(2);
   assign redir_tgt_d   = align_pc(redirect_pc);
   assign pc_in_range_d = (pc_q < PROG_END);

   assign pop_d  = !fifo_empty && instr_ready;
   assign push_d = (state_q == FETCH) && pc_in_range_d && !redirect_valid
                   && (!fifo_full || pop_d);

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_d),
      .pop_i   (pop_d),
      .flush_i (redirect_valid),
      .wdata_i ({pc_q, instruction}),
      .rdata_o (head_entry),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .one_o   (fifo_one)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= FETCH;
         pc_q     <= RESET_PC;
         halted_q <= 1'b0;
      end else if (redirect_valid) begin
         // Out-of-image targets drain the (now empty) buffer and halt next cycle.
         pc_q     <= redir_tgt_d;
         halted_q <= 1'b0;
         state_q  <= (redir_tgt_d < PROG_END) ? FETCH : DRAIN;
      end else begin
         case (state_q)
            FETCH: begin
               if (!pc_in_range_d) begin
                  state_q <= DRAIN;
               end else if (push_d) begin
                  pc_q <= pc_inc_d;
                  if (pc_inc_d >= PROG_END) state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (fifo_empty || (fifo_one && pop_d)) begin
                  state_q  <= HALTED;
                  halted_q <= 1'b1;
               end
            end
            HALTED: begin
               halted_q <= 1'b1;
            end
            default: begin
               state_q  <= FETCH;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

   assign pc          = pc_q;
   assign halted      = halted_q;
   assign instr_valid = !fifo_empty;
   // Stale storage is masked so the outputs read zero whenever nothing is valid.
   assign instr_out   = fifo_empty ? '0 : head_entry[INSTR_W-1:0];
   assign instr_pc    = fifo_empty ? '0 : head_entry[ENTRY_W-1:INSTR_W];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected PCs, a negedge
// monitor checks every accepted entry against the memory model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] pc;
   logic [15:0] instruction;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr_out;
   logic [15:0] instr_pc;
   logic        halted;

   int          checks   = 0;
   int          failures = 0;
   logic [15:0] exp_q[$];

   fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .pc             (pc),
      .instruction    (instruction),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_out      (instr_out),
      .instr_pc       (instr_pc),
      .halted         (halted)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      if (a >= 16'h0032) return 16'h0000;
      return 16'hC300 ^ {a[7:0], a[7:0]};
   endfunction

   always_comb instruction = mem_word(pc);

   task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_prog(input int from);
      for (int a = from; a < 'h32; a += 2) exp_q.push_back(16'(a));
   endtask

   task automatic do_reset(input logic ready);
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 16'h0;
      instr_ready    = ready;
      step();
      rst = 1'b0;
   endtask

   task automatic wait_drain(input string name, output int n);
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         step();
         n++;
      end
      check16({name, " drained"}, 16'(exp_q.size()), 16'd0);
      check16({name, " halted"}, {15'd0, halted}, 16'd1);
      check16({name, " valid after halt"}, {15'd0, instr_valid}, 16'd0);
   endtask

   // Monitor: every accepted entry must be the next expected one.
   always @(negedge clk) begin
      if (!rst && instr_valid && instr_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pop: got pc %h expected no entry", instr_pc);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            check16("mon instr_pc", instr_pc, e);
            check16("mon instr_out", instr_out, mem_word(e));
            check16("mon halted while valid", {15'd0, halted}, 16'd0);
         end
      end
   end

   initial begin
      int n;
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 16'h0;
      instr_ready    = 1'b1;
      step();
      step();

      // Reset values
      check16("rst pc", pc, 16'h0000);
      check16("rst valid", {15'd0, instr_valid}, 16'd0);
      check16("rst instr_out", instr_out, 16'h0000);
      check16("rst instr_pc", instr_pc, 16'h0000);
      check16("rst halted", {15'd0, halted}, 16'd0);

      // Streaming run from reset with decode always ready
      rst = 1'b0;
      expect_prog(0);
      wait_drain("stream", n);
      check16("stream cycles to halt", 16'(n), 16'd26);
      check16("stream final pc", pc, 16'h0032);

      // Back-pressure: buffer fills and pc holds
      do_reset(1'b0);
      for (int i = 0; i < 10; i++) step();
      check16("bp pc hold", pc, 16'h0004);
      check16("bp valid", {15'd0, instr_valid}, 16'd1);
      check16("bp head pc", instr_pc, 16'h0000);
      check16("bp head instr", instr_out, mem_word(16'h0000));
      expect_prog(0);
      instr_ready = 1'b1;
      wait_drain("bp", n);

      // Redirect to odd target while full and popping
      do_reset(1'b0);
      step();
      step();
      step();
      check16("redir pre pc", pc, 16'h0004);
      exp_q.push_back(16'h0000);
      expect_prog('h10);
      instr_ready    = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0011;
      step();
      redirect_valid = 1'b0;
      check16("redir valid low", {15'd0, instr_valid}, 16'd0);
      check16("redir pc", pc, 16'h0010);
      step();
      check16("redir target valid", {15'd0, instr_valid}, 16'd1);
      check16("redir target pc", instr_pc, 16'h0010);
      wait_drain("redir", n);

      // Redirect beyond the image, then back to the start
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0040;
      step();
      redirect_valid = 1'b0;
      check16("far halted clear", {15'd0, halted}, 16'd0);
      check16("far pc", pc, 16'h0040);
      check16("far valid", {15'd0, instr_valid}, 16'd0);
      step();
      check16("far halted", {15'd0, halted}, 16'd1);
      check16("far pc hold", pc, 16'h0040);
      step();
      check16("far no push", {15'd0, instr_valid}, 16'd0);
      expect_prog(0);
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0000;
      step();
      redirect_valid = 1'b0;
      check16("restart halted", {15'd0, halted}, 16'd0);
      check16("restart pc", pc, 16'h0000);
      wait_drain("restart", n);

      // Reset mid-stream with a simultaneous redirect
      do_reset(1'b0);
      for (int i = 0; i < 5; i++) step();
      rst            = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0020;
      step();
      check16("midrst pc", pc, 16'h0000);
      check16("midrst valid", {15'd0, instr_valid}, 16'd0);
      check16("midrst instr_out", instr_out, 16'h0000);
      check16("midrst instr_pc", instr_pc, 16'h0000);
      check16("midrst halted", {15'd0, halted}, 16'd0);
      rst            = 1'b0;
      redirect_valid = 1'b0;
      instr_ready    = 1'b1;
      expect_prog(0);
      wait_drain("midrst", n);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
